matvec8_stream_feeder: RTL and testbench

Host-side initiator for the matvec8 streaming interface. It buffers one K×K matrix and a FIFO of K-element vectors written over a load port. It then emits them onto the matvec input stream as "sets", with `new_matrix` flagging the first word of each set. It also forwards the matvec result stream to a downstream sink, tagging the last element of each result vector. The block sits between the host/loader logic and `matvec8_part4`, in place of a testbench driver.

---
 rtl/matvec8_stream_feeder_if.sv | 52 +++++
 rtl/matvec8_stream_feeder.sv | 255 +++++++++++++++++++++++++
 tb/tb_matvec8_stream_feeder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matvec8_stream_feeder_if.sv
// matvec8_stream_feeder_if
// Bundles the four streams around the feeder: the host load port, the matvec
// input stream, the matvec result stream and the downstream result sink.
// Modport master is the feeder side; modport slave is the environment side
// (host loader, matvec8_part4 and the result sink).
// Parameters: DW = input element width, OW = result width.

interface matvec8_stream_feeder_if #(
    parameter int DW = 14,
    parameter int OW = 28
);
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic          ld_is_matrix;

    logic          mv_in_valid;
    logic          mv_in_ready;
    logic [DW-1:0] mv_in_data;
    logic          mv_new_matrix;

    logic          mv_out_valid;
    logic          mv_out_ready;
    logic [OW-1:0] mv_out_data;

    logic          res_valid;
    logic          res_ready;
    logic [OW-1:0] res_data;
    logic          res_last;

    modport master (
        input  ld_valid, ld_data, ld_is_matrix,
        output ld_ready,
        output mv_in_valid, mv_in_data, mv_new_matrix,
        input  mv_in_ready,
        input  mv_out_valid, mv_out_data,
        output mv_out_ready,
        output res_valid, res_data, res_last,
        input  res_ready
    );

    modport slave (
        output ld_valid, ld_data, ld_is_matrix,
        input  ld_ready,
        input  mv_in_valid, mv_in_data, mv_new_matrix,
        output mv_in_ready,
        output mv_out_valid, mv_out_data,
        input  mv_out_ready,
        input  res_valid, res_data, res_last,
        output res_ready
    );
endinterface

// File: rtl/matvec8_stream_feeder.sv
// matvec8_stream_feeder
// Host-side initiator for matvec8: buffers one KxK matrix plus a FIFO of
// K-element vectors, streams them to matvec as sets (new_matrix on the first
// word of a set that carries the matrix), and forwards the result stream to a
// sink with res_last on element K-1 of each result vector.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-high
//   bus        - master modport: load port, matvec in/out streams, sink stream
//   idle       - nothing queued, nothing being sent, nothing outstanding
//   perf_busy  - cycles with idle low (saturating)
//   perf_stall - cycles with mv_in_valid && !mv_in_ready (saturating)
// Optional feature: define MATVEC_FEEDER_PERF_EN to build the two perf
// counters; without it both ports are tied to zero.
//
// state  | meaning
// IDLE   | waiting for >= K queued vector words and a free outstanding slot
// SEND_M | streaming the K*K matrix buffer; new_matrix on word 0
// SEND_V | popping K vector words from the FIFO head

module matvec8_stream_feeder #(
    parameter int K       = 8,
    parameter int DW      = 14,
    parameter int OW      = 28,
    parameter int VDEPTH  = 16,
    parameter int MAX_OUT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    matvec8_stream_feeder_if.master bus,
    output logic                    idle,
    output logic [31:0]             perf_busy,
    output logic [31:0]             perf_stall
);
    localparam int MW  = K * K;
    localparam int VW  = VDEPTH * K;
    localparam int MAW = $clog2(MW);
    localparam int VAW = $clog2(VW);
    localparam int PW  = VAW + 1;
    localparam int OCW = $clog2(MAX_OUT + 1);
    localparam int ECW = $clog2(K);

    localparam logic [MAW-1:0] M_LAST  = MAW'(MW - 1);
    localparam logic [MAW-1:0] V_LAST  = MAW'(K - 1);
    localparam logic [PW-1:0]  K_WORDS = PW'(K);
    localparam logic [PW-1:0]  V_FULL  = PW'(VW);
    localparam logic [OCW-1:0] O_MAX   = OCW'(MAX_OUT);
    localparam logic [ECW-1:0] E_LAST  = ECW'(K - 1);

    typedef enum logic [1:0] {IDLE, SEND_M, SEND_V} state_t;

    state_t         state_q, state_d;
    logic [MAW-1:0] word_cnt_q, word_cnt_d;
    logic           first_q, first_d;
    logic [MAW-1:0] mload_cnt_q, mload_cnt_d;
    logic           mat_pending_q, mat_pending_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCW-1:0] outstanding_q, outstanding_d;
    logic [ECW-1:0] elem_cnt_q, elem_cnt_d;

    logic [DW-1:0]  mat_mem  [MW];
    logic [DW-1:0]  fifo_mem [VW];

    logic [PW-1:0]  fifo_count;
    logic           fifo_full, fifo_empty;
    logic           ld_ready, ld_fire, mat_we, push, pop, mat_done;
    logic           mv_in_valid, mv_new_matrix, set_start, set_done;
    logic [DW-1:0]  mv_in_data;
    logic           res_fire, res_counted, start_ok, chain_ok;
    logic [OW-1:0]  res_data;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_count == V_FULL);
    assign fifo_empty = (fifo_count == '0);

    assign ld_ready = bus.ld_is_matrix ? (fifo_empty && state_q == IDLE)
                                       : (!fifo_full && mload_cnt_q == '0);
    assign ld_fire  = bus.ld_valid && ld_ready;
    assign mat_we   = ld_fire && bus.ld_is_matrix;
    assign push     = ld_fire && !bus.ld_is_matrix;

    assign start_ok = (fifo_count >= K_WORDS) && (outstanding_q < O_MAX);
    // On the last word of a set that word is still in fifo_count, so K more
    // words remaining means strictly more than K counted.
    assign chain_ok = (fifo_count > K_WORDS) && (outstanding_q < O_MAX);

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        first_d       = first_q;
        mv_in_valid   = 1'b0;
        mv_new_matrix = 1'b0;
        mv_in_data    = '0;
        pop           = 1'b0;
        mat_done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d    = mat_pending_q ? SEND_M : SEND_V;
                    word_cnt_d = '0;
                    first_d    = 1'b1;
                end
            end
            SEND_M: begin
                mv_in_valid   = 1'b1;
                mv_in_data    = mat_mem[word_cnt_q];
                mv_new_matrix = (word_cnt_q == '0);
                if (bus.mv_in_ready) begin
                    first_d = 1'b0;
                    if (word_cnt_q == M_LAST) begin
                        word_cnt_d = '0;
                        mat_done   = 1'b1;
                        state_d    = SEND_V;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            SEND_V: begin
                mv_in_valid = 1'b1;
                mv_in_data  = fifo_mem[rd_ptr_q[VAW-1:0]];
                if (bus.mv_in_ready) begin
                    pop     = 1'b1;
                    first_d = 1'b0;
                    if (word_cnt_q == V_LAST) begin
                        word_cnt_d = '0;
                        // A matrix can only be loaded while IDLE, so a chained
                        // set is always vector-only.
                        if (chain_ok) begin
                            state_d = SEND_V;
                            first_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign set_start   = mv_in_valid && bus.mv_in_ready && first_q;
    assign res_fire    = bus.mv_out_valid && bus.res_ready;
    // Results arriving with nothing outstanding are forwarded but not counted.
    assign res_counted = res_fire && (outstanding_q != '0);
    assign set_done    = res_counted && (elem_cnt_q == E_LAST);

    always_comb begin
        mload_cnt_d   = mload_cnt_q;
        mat_pending_d = mat_pending_q;
        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        elem_cnt_d    = elem_cnt_q;
        outstanding_d = outstanding_q;
        if (mat_we) begin
            if (mload_cnt_q == M_LAST) begin
                mload_cnt_d   = '0;
                mat_pending_d = 1'b1;
            end else begin
                mload_cnt_d = mload_cnt_q + 1'b1;
            end
        end
        if (mat_done) begin
            mat_pending_d = 1'b0;
        end
        if (res_counted) begin
            elem_cnt_d = (elem_cnt_q == E_LAST) ? '0 : elem_cnt_q + 1'b1;
        end
        case ({set_start, set_done})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            first_q       <= 1'b0;
            mload_cnt_q   <= '0;
            mat_pending_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            elem_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            first_q       <= first_d;
            mload_cnt_q   <= mload_cnt_d;
            mat_pending_q <= mat_pending_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            elem_cnt_q    <= elem_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mat_we) begin
            mat_mem[mload_cnt_q] <= bus.ld_data;
        end
        if (push) begin
            fifo_mem[wr_ptr_q[VAW-1:0]] <= bus.ld_data;
        end
    end

    assign res_data          = bus.mv_out_data;
    assign bus.ld_ready      = ld_ready;
    assign bus.mv_in_valid   = mv_in_valid;
    assign bus.mv_in_data    = mv_in_data;
    assign bus.mv_new_matrix = mv_new_matrix;
    assign bus.res_valid     = bus.mv_out_valid;
    assign bus.mv_out_ready  = bus.res_ready;
    assign bus.res_data      = res_data;
    assign bus.res_last      = (elem_cnt_q == E_LAST);

    assign idle = fifo_empty && (state_q == IDLE) && (mload_cnt_q == '0) && (outstanding_q == '0);

`ifdef MATVEC_FEEDER_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if (!idle && perf_busy_q != '1) begin
            perf_busy_d = perf_busy_q + 32'd1;
        end
        if (mv_in_valid && !bus.mv_in_ready && perf_stall_q != '1) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_busy  = perf_busy_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_busy  = '0;
    assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_matvec8_stream_feeder.sv
module tb_matvec8_stream_feeder;
    localparam int K = 8, DW = 14, OW = 28, VDEPTH = 16, MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        idle;
    logic [31:0] perf_busy, perf_stall;
    int          vectors = 0;
    int          miscompares = 0;

    // monitor state, cleared while reset is high
    int            n_in, nm_ones, n_res, n_last, run, max_run;
    logic [DW-1:0] in_word [128];
    logic          in_nm   [128];
    logic [OW-1:0] res_log [64];
    logic          last_flag [64];

    matvec8_stream_feeder_if #(.DW(DW), .OW(OW)) bus ();

    matvec8_stream_feeder #(.K(K), .DW(DW), .OW(OW), .VDEPTH(VDEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset), .bus(bus), .idle(idle),
        .perf_busy(perf_busy), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            n_in = 0; nm_ones = 0; n_res = 0; n_last = 0; run = 0; max_run = 0;
        end else begin
            if (bus.mv_in_valid && bus.mv_in_ready) begin
                if (n_in < 128) begin
                    in_word[n_in] = bus.mv_in_data;
                    in_nm[n_in]   = bus.mv_new_matrix;
                end
                if (bus.mv_new_matrix) nm_ones++;
                n_in++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (bus.res_valid && bus.res_ready) begin
                if (n_res < 64) begin
                    res_log[n_res]   = bus.res_data;
                    last_flag[n_res] = bus.res_last;
                end
                if (bus.res_last) n_last++;
                n_res++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic load_word(input logic is_m, input logic [DW-1:0] d);
        int t = 0;
        bus.ld_valid = 1'b1; bus.ld_is_matrix = is_m; bus.ld_data = d;
        #1;
        while (!bus.ld_ready && t < 500) begin
            step(); #1; t++;
        end
        if (t >= 500) begin
            vectors++; miscompares++;
            $display("FAIL load_timeout: ld_ready stayed %b, required 1", bus.ld_ready);
            #3;
        end else begin
            @(posedge clk); #1;
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic drive_results(input int n, input int base);
        bus.mv_out_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.mv_out_data = OW'(base + i);
            step();
        end
        bus.mv_out_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b want 1", idle); end
        vectors++; if (bus.ld_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ld_ready: got %b want 1", bus.ld_ready); end
        vectors++; if (bus.mv_in_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mv_in_valid: got %b want 0", bus.mv_in_valid); end
        vectors++; if (bus.mv_new_matrix !== 1'b0) begin miscompares++; $display("FAIL reset_new_matrix: got %b want 0", bus.mv_new_matrix); end
        vectors++; if (bus.res_last !== 1'b0) begin miscompares++; $display("FAIL reset_res_last: got %b want 0", bus.res_last); end
        vectors++; if (perf_busy !== 32'd0) begin miscompares++; $display("FAIL reset_perf_busy: got %0d want 0", perf_busy); end
        vectors++; if (perf_stall !== 32'd0) begin miscompares++; $display("FAIL reset_perf_stall: got %0d want 0", perf_stall); end
    endtask

    task automatic test_matrix_two_vectors();
        logic [DW-1:0] exp_w;
        do_reset();
        bus.mv_in_ready = 1'b1; bus.res_ready = 1'b1;
        for (int i = 0; i < 64; i++) load_word(1'b1, DW'(i + 1));
        for (int i = 0; i < 16; i++) load_word(1'b0, DW'(101 + i));
        for (int t = 0; t < 400 && n_in < 80; t++) step();
        repeat (4) step();
        vectors++; if (n_in !== 80) begin miscompares++; $display("FAIL mv_word_count: got %0d want 80", n_in); end
        for (int i = 0; i < 80; i++) begin
            exp_w = (i < 64) ? DW'(i + 1) : DW'(101 + i - 64);
            vectors++;
            if (in_word[i] !== exp_w) begin miscompares++; $display("FAIL mv_word[%0d]: got %0d want %0d", i, in_word[i], exp_w); end
        end
        vectors++; if (nm_ones !== 1) begin miscompares++; $display("FAIL new_matrix_count: got %0d want 1", nm_ones); end
        vectors++; if (in_nm[0] !== 1'b1) begin miscompares++; $display("FAIL new_matrix_w0: got %b want 1", in_nm[0]); end
        vectors++; if (in_nm[64] !== 1'b0) begin miscompares++; $display("FAIL new_matrix_w64: got %b want 0", in_nm[64]); end
        vectors++; if (in_nm[72] !== 1'b0) begin miscompares++; $display("FAIL new_matrix_w72: got %b want 0", in_nm[72]); end
        vectors++; if (idle !== 1'b0) begin miscompares++; $display("FAIL idle_outstanding: got %b want 0", idle); end
        drive_results(16, 1000);
        step();
        vectors++; if (n_res !== 16) begin miscompares++; $display("FAIL res_count: got %0d want 16", n_res); end
        vectors++; if (n_last !== 2) begin miscompares++; $display("FAIL res_last_count: got %0d want 2", n_last); end
        vectors++; if (last_flag[7] !== 1'b1) begin miscompares++; $display("FAIL res_last_e7: got %b want 1", last_flag[7]); end
        vectors++; if (last_flag[15] !== 1'b1) begin miscompares++; $display("FAIL res_last_e15: got %b want 1", last_flag[15]); end
        vectors++; if (last_flag[8] !== 1'b0) begin miscompares++; $display("FAIL res_last_e8: got %b want 0", last_flag[8]); end
        vectors++; if (res_log[15] !== OW'(1015)) begin miscompares++; $display("FAIL res_data_e15: got %0d want 1015", res_log[15]); end
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL idle_after_results: got %b want 1", idle); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.mv_in_ready = 1'b0; bus.res_ready = 1'b0;
        for (int i = 0; i < 24; i++) load_word(1'b0, DW'(200 + i));
        step();
        bus.mv_in_ready = 1'b1;
        for (int t = 0; t < 100 && n_in < 24; t++) step();
        repeat (4) step();
        vectors++; if (n_in !== 24) begin miscompares++; $display("FAIL b2b_words: got %0d want 24", n_in); end
        vectors++; if (max_run !== 24) begin miscompares++; $display("FAIL b2b_run: got %0d want 24", max_run); end
        vectors++; if (nm_ones !== 0) begin miscompares++; $display("FAIL b2b_new_matrix: got %0d want 0", nm_ones); end
        vectors++; if (in_word[23] !== DW'(223)) begin miscompares++; $display("FAIL b2b_last_word: got %0d want 223", in_word[23]); end
        vectors++; if (bus.mv_in_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_drop: got %b want 0", bus.mv_in_valid); end
        vectors++; if (idle !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got %b want 0", idle); end
    endtask

    task automatic test_outstanding_cap();
        do_reset();
        bus.mv_in_ready = 1'b1; bus.res_ready = 1'b0;
        for (int i = 0; i < 48; i++) load_word(1'b0, DW'(300 + i));
        repeat (100) step();
        vectors++; if (n_in !== 32) begin miscompares++; $display("FAIL cap_words: got %0d want 32", n_in); end
        vectors++; if (bus.mv_in_valid !== 1'b0) begin miscompares++; $display("FAIL cap_valid: got %b want 0", bus.mv_in_valid); end
        bus.res_ready = 1'b1;
        drive_results(8, 2000);
        repeat (40) step();
        vectors++; if (n_in !== 40) begin miscompares++; $display("FAIL cap_resume_words: got %0d want 40", n_in); end
        vectors++; if (n_last !== 1) begin miscompares++; $display("FAIL cap_res_last: got %0d want 1", n_last); end
        vectors++; if (in_word[39] !== DW'(339)) begin miscompares++; $display("FAIL cap_word39: got %0d want 339", in_word[39]); end
    endtask

    task automatic test_load_rules();
        do_reset();
        bus.res_ready = 1'b1; bus.mv_in_ready = 1'b1;
        drive_results(8, 3000);
        step();
        vectors++; if (n_last !== 0) begin miscompares++; $display("FAIL underflow_last: got %0d want 0", n_last); end
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL underflow_idle: got %b want 1", idle); end
        load_word(1'b0, DW'(5));
        bus.ld_valid = 1'b1; bus.ld_is_matrix = 1'b1; bus.ld_data = DW'(9);
        #1;
        vectors++; if (bus.ld_ready !== 1'b0) begin miscompares++; $display("FAIL matrix_vs_fifo: got %b want 0", bus.ld_ready); end
        bus.ld_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) load_word(1'b1, DW'(i + 1));
        bus.ld_valid = 1'b1; bus.ld_is_matrix = 1'b0; bus.ld_data = DW'(7);
        #1;
        vectors++; if (bus.ld_ready !== 1'b0) begin miscompares++; $display("FAIL vector_vs_mload: got %b want 0", bus.ld_ready); end
        vectors++; if (idle !== 1'b0) begin miscompares++; $display("FAIL partial_idle: got %b want 0", idle); end
        vectors++; if (dut.mat_pending_q !== 1'b0) begin miscompares++; $display("FAIL partial_pending: got %b want 0", dut.mat_pending_q); end
        bus.ld_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_send();
        int t = 0;
        do_reset();
        bus.mv_in_ready = 1'b1; bus.res_ready = 1'b1;
        for (int i = 0; i < 64; i++) load_word(1'b1, DW'(i + 1));
        for (int i = 0; i < 8; i++) load_word(1'b0, DW'(400 + i));
        while (n_in < 20 && t < 300) begin step(); t++; end
        vectors++; if (n_in !== 20) begin miscompares++; $display("FAIL mid_reach_w20: got %0d want 20", n_in); end
        vectors++; if (in_word[19] !== DW'(20)) begin miscompares++; $display("FAIL mid_word19: got %0d want 20", in_word[19]); end
        vectors++; if (bus.mv_in_valid !== 1'b1) begin miscompares++; $display("FAIL mid_valid_before: got %b want 1", bus.mv_in_valid); end
        reset = 1'b1;
        step();
        vectors++; if (bus.mv_in_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid_after: got %b want 0", bus.mv_in_valid); end
        vectors++; if (bus.mv_new_matrix !== 1'b0) begin miscompares++; $display("FAIL mid_new_matrix: got %b want 0", bus.mv_new_matrix); end
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL mid_idle: got %b want 1", idle); end
        vectors++; if (bus.ld_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ld_ready: got %b want 1", bus.ld_ready); end
        vectors++; if (bus.res_last !== 1'b0) begin miscompares++; $display("FAIL mid_res_last: got %b want 0", bus.res_last); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_perf_counters();
        int t = 0;
        do_reset();
        bus.mv_in_ready = 1'b1; bus.res_ready = 1'b1;
        for (int i = 0; i < 8; i++) load_word(1'b0, DW'(500 + i));
        while (!bus.mv_in_valid && t < 20) begin step(); t++; end
        vectors++; if (bus.mv_in_valid !== 1'b1) begin miscompares++; $display("FAIL perf_set_start: got %b want 1", bus.mv_in_valid); end
        bus.mv_in_ready = 1'b0;
        repeat (5) step();
        bus.mv_in_ready = 1'b1;
        repeat (20) step();
        vectors++; if (n_in !== 8) begin miscompares++; $display("FAIL perf_words: got %0d want 8", n_in); end
`ifdef MATVEC_FEEDER_PERF_EN
        vectors++; if (perf_stall !== 32'd5) begin miscompares++; $display("FAIL perf_stall: got %0d want 5", perf_stall); end
        vectors++; if (perf_busy === 32'd0) begin miscompares++; $display("FAIL perf_busy: got 0 want nonzero"); end
`else
        vectors++; if (perf_stall !== 32'd0) begin miscompares++; $display("FAIL perf_stall_off: got %0d want 0", perf_stall); end
        vectors++; if (perf_busy !== 32'd0) begin miscompares++; $display("FAIL perf_busy_off: got %0d want 0", perf_busy); end
`endif
    endtask

    initial begin
        bus.ld_valid = 1'b0; bus.ld_is_matrix = 1'b0; bus.ld_data = '0;
        bus.mv_in_ready = 1'b0; bus.mv_out_valid = 1'b0; bus.mv_out_data = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_matrix_two_vectors();
        test_back_to_back();
        test_outstanding_cap();
        test_load_rules();
        test_reset_mid_send();
        test_perf_counters();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
